// File: rtl/led_pwm_user_logic_if.sv
// Register-access bundle between the AXI-Lite slave front end and the LED logic.
interface led_pwm_user_logic_if #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32
);
    logic                    slv_reg_wren;
    logic [ADDR_WIDTH-1:0]   axi_awaddr;
    logic [DATA_WIDTH-1:0]   S_AXI_WDATA;
    logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB;
    logic [ADDR_WIDTH-1:0]   axi_araddr;
    logic [DATA_WIDTH-1:0]   reg_data_out;

    modport master (
        output slv_reg_wren,
        output axi_awaddr,
        output S_AXI_WDATA,
        output S_AXI_WSTRB,
        output axi_araddr,
        input  reg_data_out
    );

    modport slave (
        input  slv_reg_wren,
        input  axi_awaddr,
        input  S_AXI_WDATA,
        input  S_AXI_WSTRB,
        input  axi_araddr,
        output reg_data_out
    );
endinterface

// File: rtl/led_pwm_user_logic.sv
// Per-channel static / blink / PWM LED driver with a byte-strobed register map.
module led_pwm_user_logic #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6,
    parameter int ADDR_LSB           = 2,
    parameter int NUM_LEDS           = 8,
    parameter int PWM_BITS           = 8,
    parameter int PRESCALE_WIDTH     = 16
) (
    input  logic                 S_AXI_ACLK,
    input  logic                 S_AXI_ARESETN,
    led_pwm_user_logic_if.slave  bus,
    output logic [NUM_LEDS-1:0]  LED
);
    localparam int WW = C_S_AXI_ADDR_WIDTH - ADDR_LSB;
    localparam int PW = PRESCALE_WIDTH;
    localparam int MW = 2 * NUM_LEDS;
    localparam int DW = C_S_AXI_DATA_WIDTH;

    logic                en;
    logic                inv;
    logic [NUM_LEDS-1:0] direct;
    logic [MW-1:0]       mode;
    logic [PW-1:0]       prescale;
    logic [PW-1:0]       blink_period;
    logic [PWM_BITS-1:0] duty [NUM_LEDS];

    logic [PW-1:0]       presc_cnt;
    logic [PW-1:0]       blink_cnt;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic                blink_phase;

    logic [WW-1:0]       widx;
    logic [WW-1:0]       ridx;
    logic [DW-1:0]       wd;
    logic [DW-1:0]       bm;
    logic                we_ctrl;
    logic                we_direct;
    logic                we_mode;
    logic                we_presc;
    logic                we_blink;
    logic [NUM_LEDS-1:0] we_duty;
    logic                clr;
    logic                tick;
    logic                blink_wrap;
    logic [NUM_LEDS-1:0] raw;
    logic [DW-1:0]       rdata;
    logic                unused_bits;

    assign widx = bus.axi_awaddr[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB];
    assign ridx = bus.axi_araddr[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB];
    assign wd   = bus.S_AXI_WDATA;

    assign unused_bits = ^{bus.axi_awaddr[ADDR_LSB-1:0],
                           bus.axi_araddr[ADDR_LSB-1:0], wd, bm};

    always_comb begin
        bm = '0;
        for (int b = 0; b < DW / 8; b++) begin
            bm[8*b +: 8] = {8{bus.S_AXI_WSTRB[b]}};
        end
    end

    always_comb begin
        we_ctrl   = 1'b0;
        we_direct = 1'b0;
        we_mode   = 1'b0;
        we_presc  = 1'b0;
        we_blink  = 1'b0;
        we_duty   = '0;
        if (bus.slv_reg_wren) begin
            unique case (1'b1)
                (widx == WW'(0)): we_ctrl   = 1'b1;
                (widx == WW'(1)): we_direct = 1'b1;
                (widx == WW'(2)): we_mode   = 1'b1;
                (widx == WW'(3)): we_presc  = 1'b1;
                (widx == WW'(4)): we_blink  = 1'b1;
                default: begin
                    for (int i = 0; i < NUM_LEDS; i++) begin
                        if (widx == WW'(8 + i)) we_duty[i] = 1'b1;
                    end
                end
            endcase
        end
    end

    // CLR is an action, not state: it never lands in the CTRL register.
    assign clr = we_ctrl & bus.S_AXI_WSTRB[0] & wd[2];

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            en           <= 1'b1;
            inv          <= 1'b0;
            direct       <= '0;
            mode         <= '0;
            prescale     <= '0;
            blink_period <= '0;
            for (int i = 0; i < NUM_LEDS; i++) duty[i] <= '0;
        end else begin
            if (we_ctrl && bus.S_AXI_WSTRB[0]) begin
                en  <= wd[0];
                inv <= wd[1];
            end
            if (we_direct) begin
                direct <= (direct & ~bm[NUM_LEDS-1:0])
                        | (wd[NUM_LEDS-1:0] & bm[NUM_LEDS-1:0]);
            end
            if (we_mode) begin
                mode <= (mode & ~bm[MW-1:0]) | (wd[MW-1:0] & bm[MW-1:0]);
            end
            if (we_presc) begin
                prescale <= (prescale & ~bm[PW-1:0]) | (wd[PW-1:0] & bm[PW-1:0]);
            end
            if (we_blink) begin
                blink_period <= (blink_period & ~bm[PW-1:0])
                              | (wd[PW-1:0] & bm[PW-1:0]);
            end
            for (int i = 0; i < NUM_LEDS; i++) begin
                if (we_duty[i]) begin
                    duty[i] <= (duty[i] & ~bm[PWM_BITS-1:0])
                             | (wd[PWM_BITS-1:0] & bm[PWM_BITS-1:0]);
                end
            end
        end
    end

    // Compares use the registers as they stood before any write this cycle.
    assign tick       = (presc_cnt >= prescale);
    assign blink_wrap = (blink_cnt >= blink_period);

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            presc_cnt   <= '0;
            pwm_cnt     <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (clr) begin
            presc_cnt   <= '0;
            pwm_cnt     <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (tick) begin
            presc_cnt <= '0;
            pwm_cnt   <= pwm_cnt + PWM_BITS'(1);
            if (blink_wrap) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + PW'(1);
            end
        end else begin
            presc_cnt <= presc_cnt + PW'(1);
        end
    end

    always_comb begin
        raw = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            case (mode[2*i +: 2])
                2'b00:   raw[i] = direct[i];
                2'b01:   raw[i] = blink_phase & direct[i];
                2'b10:   raw[i] = (pwm_cnt < duty[i]);
                default: raw[i] = 1'b0;
            endcase
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            LED <= '0;
        end else begin
            LED <= en ? (raw ^ {NUM_LEDS{inv}}) : '0;
        end
    end

    always_comb begin
        rdata = '0;
        case (ridx)
            WW'(0): rdata[1:0]          = {inv, en};
            WW'(1): rdata[NUM_LEDS-1:0] = direct;
            WW'(2): rdata[MW-1:0]       = mode;
            WW'(3): rdata[PW-1:0]       = prescale;
            WW'(4): rdata[PW-1:0]       = blink_period;
            default: begin
                for (int i = 0; i < NUM_LEDS; i++) begin
                    if (ridx == WW'(8 + i)) rdata[PWM_BITS-1:0] = duty[i];
                end
            end
        endcase
    end

    assign bus.reg_data_out = rdata;
endmodule

// File: tb/tb_led_pwm_user_logic.sv
// Bench: 8-LED and 4-LED instances driven in lockstep against a register-map model.
module tb_led_pwm_user_logic;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        wren;
    logic [5:0]  awaddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [5:0]  araddr;
    logic [7:0]  led8;
    logic [3:0]  led4;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    led_pwm_user_logic_if #(.ADDR_WIDTH(6), .DATA_WIDTH(32)) b8 ();
    led_pwm_user_logic_if #(.ADDR_WIDTH(6), .DATA_WIDTH(32)) b4 ();

    assign b8.slv_reg_wren = wren;
    assign b8.axi_awaddr   = awaddr;
    assign b8.S_AXI_WDATA  = wdata;
    assign b8.S_AXI_WSTRB  = wstrb;
    assign b8.axi_araddr   = araddr;
    assign b4.slv_reg_wren = wren;
    assign b4.axi_awaddr   = awaddr;
    assign b4.S_AXI_WDATA  = wdata;
    assign b4.S_AXI_WSTRB  = wstrb;
    assign b4.axi_araddr   = araddr;

    led_pwm_user_logic #(.NUM_LEDS(8)) u8 (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rstn),
        .bus           (b8.slave),
        .LED           (led8)
    );

    led_pwm_user_logic #(.NUM_LEDS(4)) u4 (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rstn),
        .bus           (b4.slave),
        .LED           (led4)
    );

    // Model: the 16-word map as an 8-LED block sees it, plus the shared counters.
    typedef struct packed {
        logic [15:0][31:0] r;
        logic [15:0]       presc;
        logic [15:0]       bcnt;
        logic [7:0]        pwm;
        logic              phase;
        logic [7:0]        led;
    } ms_t;

    ms_t m;

    function automatic logic [31:0] field_mask(input int w);
        if (w == 0) return 32'h3;
        if (w == 1) return 32'hFF;
        if (w >= 2 && w <= 4) return 32'hFFFF;
        if (w >= 8) return 32'hFF;
        return 32'h0;
    endfunction

    function automatic ms_t reset_ms();
        ms_t s;
        s = '0;
        s.r[0] = 32'h1;
        return s;
    endfunction

    function automatic ms_t step(input ms_t s, input logic we, input logic [5:0] aa,
                                 input logic [31:0] d, input logic [3:0] st);
        ms_t n;
        int w;
        int md;
        logic rawb;
        logic clr;
        logic tick;
        n = s;
        w = int'(aa[5:2]);
        clr = we && (w == 0) && st[0] && d[2];
        tick = (s.presc >= s.r[3][15:0]);
        for (int i = 0; i < 8; i++) begin
            md = int'(s.r[2][2*i +: 2]);
            if (md == 0) rawb = s.r[1][i];
            else if (md == 1) rawb = s.phase & s.r[1][i];
            else if (md == 2) rawb = (s.pwm < s.r[8+i][7:0]);
            else rawb = 1'b0;
            n.led[i] = s.r[0][0] ? (rawb ^ s.r[0][1]) : 1'b0;
        end
        if (clr) begin
            n.presc = 0;
            n.pwm = 0;
            n.bcnt = 0;
            n.phase = 0;
        end else if (tick) begin
            n.presc = 0;
            n.pwm = s.pwm + 8'd1;
            if (s.bcnt >= s.r[4][15:0]) begin
                n.bcnt = 0;
                n.phase = !s.phase;
            end else begin
                n.bcnt = s.bcnt + 16'd1;
            end
        end else begin
            n.presc = s.presc + 16'd1;
        end
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (st[b]) n.r[w][8*b +: 8] = d[8*b +: 8];
            end
            n.r[w] = n.r[w] & field_mask(w);
        end
        return n;
    endfunction

    function automatic logic [31:0] exp_rd(input ms_t s, input int w, input int nl);
        logic [31:0] v;
        v = s.r[w];
        if (w == 1) v = v & ((32'h1 << nl) - 32'h1);
        if (w == 2) v = v & ((32'h1 << (2 * nl)) - 32'h1);
        if (w >= 8 && (w - 8) >= nl) v = 32'h0;
        return v;
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) m <= reset_ms();
        else m <= step(m, wren, awaddr, wdata, wstrb);
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rstn) begin
            check("model_led8", {24'h0, led8}, {24'h0, m.led});
            check("model_led4", {28'h0, led4}, {28'h0, m.led[3:0]});
            check("model_rd8", b8.reg_data_out, exp_rd(m, int'(araddr[5:2]), 8));
            check("model_rd4", b4.reg_data_out, exp_rd(m, int'(araddr[5:2]), 4));
        end
    end

    task automatic wr(input int w, input logic [31:0] d, input logic [3:0] s);
        wren = 1'b1;
        awaddr = 6'(w << 2);
        wdata = d;
        wstrb = s;
        @(posedge clk);
        #1;
        wren = 1'b0;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rd(input int w, output logic [31:0] v8, output logic [31:0] v4);
        araddr = 6'(w << 2);
        #1;
        v8 = b8.reg_data_out;
        v4 = b4.reg_data_out;
    endtask

    task automatic wait_chg(output int n);
        logic p;
        p = led8[0];
        n = 0;
        while (led8[0] === p && n < 200) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic count_hi(input int len, output int hi);
        hi = 0;
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            hi += int'(led8[0]);
        end
    endtask

    logic [31:0] v8;
    logic [31:0] v4;
    int n;
    int hi;
    int w;
    logic [31:0] d;

    initial begin
        wren = 1'b0;
        awaddr = '0;
        wdata = '0;
        wstrb = '0;
        araddr = '0;
        cyc(3);
        check("rst_led8", {24'h0, led8}, 32'h0);
        rd(0, v8, v4);
        check("rst_ctrl", v8, 32'h1);
        rstn = 1'b1;
        cyc(1);
        check("post_rst_led8", {24'h0, led8}, 32'h0);
        rd(0, v8, v4);
        check("post_rst_ctrl", v8, 32'h1);
        rd(2, v8, v4);
        check("post_rst_mode", v8, 32'h0);

        wr(1, 32'h0000_00A5, 4'h1);
        cyc(1);
        check("static_a5", {24'h0, led8}, 32'hA5);
        check("static_a5_n4", {28'h0, led4}, 32'h5);
        wr(1, 32'hFFFF_FFFF, 4'h2);
        cyc(2);
        check("strb_ignored", {24'h0, led8}, 32'hA5);
        wr(0, 32'h3, 4'h1);
        cyc(1);
        check("inv_5a", {24'h0, led8}, 32'h5A);
        wr(0, 32'h1, 4'h1);

        wr(2, 32'h2, 4'h3);
        wr(3, 32'h0, 4'h3);
        wr(8, 32'd64, 4'h1);
        cyc(4);
        count_hi(256, hi);
        check("pwm_64", hi, 64);
        wr(8, 32'd0, 4'h1);
        cyc(4);
        count_hi(256, hi);
        check("pwm_0", hi, 0);
        wr(8, 32'd255, 4'h1);
        cyc(4);
        count_hi(256, hi);
        check("pwm_255", hi, 255);

        wr(2, 32'h1, 4'h3);
        wr(1, 32'h1, 4'h1);
        wr(3, 32'd3, 4'h3);
        wr(4, 32'd4, 4'h3);
        wait_chg(n);
        wait_chg(n);
        wait_chg(n);
        check("blink_half1", n, 20);
        wait_chg(n);
        check("blink_half2", n, 20);
        wr(1, 32'h0, 4'h1);
        cyc(2);
        count_hi(60, hi);
        check("blink_direct0", hi, 0);
        wr(1, 32'h1, 4'h1);
        n = 0;
        while (led8[0] !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("blink_high_seen", {31'h0, led8[0]}, 32'h1);
        #2;
        rstn = 1'b0;
        #1;
        check("async_rst_led8", {24'h0, led8}, 32'h0);
        check("async_rst_led4", {28'h0, led4}, 32'h0);
        cyc(2);
        rstn = 1'b1;
        cyc(1);
        rd(0, v8, v4);
        check("rerst_ctrl", v8, 32'h1);
        rd(4, v8, v4);
        check("rerst_blink", v8, 32'h0);

        wr(2, 32'h2, 4'h3);
        wr(3, 32'h0, 4'h3);
        wr(8, 32'h1, 4'h1);
        cyc(3);
        wr(0, 32'h5, 4'h1);
        rd(0, v8, v4);
        check("clr_ctrl", v8, 32'h1);
        cyc(1);
        check("clr_pwm0", {24'h0, led8}, 32'h01);
        cyc(1);
        check("clr_pwm1", {24'h0, led8}, 32'h00);

        wr(10, 32'h80, 4'hF);
        rd(10, v8, v4);
        check("duty2_n4", v4, 32'h80);
        check("duty2_n8", v8, 32'h80);
        wr(13, 32'h1234, 4'hF);
        rd(13, v8, v4);
        check("word13_n4", v4, 32'h0);
        wr(6, 32'hFFFF_FFFF, 4'hF);
        rd(6, v8, v4);
        check("word6_n4", v4, 32'h0);
        check("word6_n8", v8, 32'h0);
        wr(2, 32'h0C, 4'h1);
        wr(1, 32'hF, 4'h1);
        cyc(2);
        check("mode11_led1", {31'h0, led4[1]}, 32'h0);
        check("mode11_led4", {28'h0, led4}, 32'hD);

        for (int c = 0; c < 4000; c++) begin
            w = $urandom_range(0, 15);
            d = $urandom;
            if (w == 3 || w == 4) d = 32'($urandom_range(0, 6));
            if (w == 0) begin
                d = {29'h0, ($urandom_range(0, 7) == 0), 1'($urandom),
                     ($urandom_range(0, 3) != 0)};
            end
            wren = ($urandom_range(0, 2) == 0);
            awaddr = 6'(w << 2);
            wdata = d;
            wstrb = 4'($urandom);
            araddr = 6'($urandom);
            @(posedge clk);
            #1;
        end
        wren = 1'b0;
        cyc(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
